instrument_meter: RTL and testbench

Per-instrument level meter in the `clk_pixel` domain that consumes the per-frame 8-bit peak intensities produced by the audio-side note tracker. Once per frame it applies instant-attack / linear-decay ballistics plus a peak-hold marker. It then rasterises one vertical bar per instrument against the pixel counters. Its registered bar and peak pixel flags feed the video compositor.

---
 rtl/instrument_meter.sv | 120 ++++++++++++
 tb/tb_instrument_meter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instrument_meter.sv
// instrument_meter: per-instrument level ballistics and vertical-bar rasteriser.
// Define METER_PEAK_MARKER_EN to compile in the peak-hold marker.
module instrument_meter #(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int DECAY_STEP       = 4,
    parameter int HOLD_FRAMES      = 15,
    parameter int BAR_X0           = 32,
    parameter int BAR_WIDTH        = 64,
    parameter int BAR_SPACING      = 16,
    parameter int BAR_Y_BOTTOM     = 700
) (
    input  logic        clk_pixel,
    input  logic        rst,
    input  logic        new_frame,
    input  logic [7:0]  max_sample_intensity [INSTRUMENT_COUNT],
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        active_draw,
    output logic        pixel_valid,
    output logic        bar_pixel,
    output logic        peak_pixel,
    output logic [7:0]  bar_index,
    output logic [7:0]  bar_level [INSTRUMENT_COUNT]
);
    localparam int IW = INSTRUMENT_COUNT > 1 ? $clog2(INSTRUMENT_COUNT) : 1;
    localparam logic [7:0] DS = 8'(DECAY_STEP);
    logic [7:0]    level      [INSTRUMENT_COUNT];
    logic [7:0]    level_next [INSTRUMENT_COUNT];
    logic          hit_c, htv_c;
    logic [IW-1:0] idx_c;
    int            hx, dv;
    logic          s1_hit, s1_htv, s1_act;
    logic [IW-1:0] s1_idx;
    logic [7:0]    s1_ht, lvl_sel;
    always_comb begin
        for (int i = 0; i < INSTRUMENT_COUNT; i++)
            level_next[i] = max_sample_intensity[i] >= level[i] ? max_sample_intensity[i] :
                            level[i] > DS ? level[i] - DS : 8'd0;
    end
    always_ff @(posedge clk_pixel) begin
        for (int i = 0; i < INSTRUMENT_COUNT; i++)
            if (rst) level[i] <= 8'd0;
            else if (new_frame) level[i] <= level_next[i];
    end
    assign bar_level = level;
    // scan from the top so the lowest overlapping index wins
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        hx = int'(h_count);
        dv = BAR_Y_BOTTOM - int'(v_count);
        for (int i = INSTRUMENT_COUNT - 1; i >= 0; i--)
            if (hx >= BAR_X0 + i * (BAR_WIDTH + BAR_SPACING) &&
                hx <  BAR_X0 + i * (BAR_WIDTH + BAR_SPACING) + BAR_WIDTH) begin
                hit_c = 1'b1;
                idx_c = IW'(i);
            end
        htv_c = dv >= 0 && dv <= 255;
    end
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            s1_hit <= 1'b0;
            s1_htv <= 1'b0;
            s1_act <= 1'b0;
            s1_idx <= '0;
            s1_ht  <= 8'd0;
        end else begin
            s1_hit <= hit_c;
            s1_htv <= htv_c;
            s1_act <= active_draw;
            s1_idx <= idx_c;
            s1_ht  <= dv[7:0];
        end
    end
    always_comb begin
        lvl_sel = 8'd0;
        for (int i = 0; i < INSTRUMENT_COUNT; i++)
            if (s1_idx == IW'(i)) lvl_sel = level[i];
    end
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            bar_pixel   <= 1'b0;
            bar_index   <= 8'd0;
        end else begin
            pixel_valid <= s1_act;
            bar_pixel   <= s1_act & s1_hit & s1_htv & (s1_ht < lvl_sel);
            bar_index   <= (s1_act & s1_hit) ? 8'(s1_idx) : 8'd0;
        end
    end
`ifdef METER_PEAK_MARKER_EN
    logic [7:0] peak [INSTRUMENT_COUNT];
    logic [7:0] hold [INSTRUMENT_COUNT];
    logic [7:0] pk_sel;
    always_ff @(posedge clk_pixel) begin
        for (int i = 0; i < INSTRUMENT_COUNT; i++)
            if (rst) begin
                peak[i] <= 8'd0;
                hold[i] <= 8'd0;
            end else if (new_frame) begin
                if (max_sample_intensity[i] >= peak[i]) begin
                    peak[i] <= max_sample_intensity[i];
                    hold[i] <= 8'(HOLD_FRAMES);
                end else if (hold[i] != 8'd0) hold[i] <= hold[i] - 8'd1;
                else peak[i] <= peak[i] > level_next[i] ? peak[i] - 8'd1 : level_next[i];
            end
    end
    always_comb begin
        pk_sel = 8'd0;
        for (int i = 0; i < INSTRUMENT_COUNT; i++)
            if (s1_idx == IW'(i)) pk_sel = peak[i];
    end
    always_ff @(posedge clk_pixel) begin
        if (rst) peak_pixel <= 1'b0;
        else peak_pixel <= s1_act & s1_hit & s1_htv & (pk_sel != 8'd0) & (s1_ht == pk_sel);
    end
`else
    assign peak_pixel = 1'b0;
`endif
endmodule

// File: tb/tb_instrument_meter.sv
// tb_instrument_meter: directed checks of ballistics, rendering, pipeline and reset.
module tb_instrument_meter;
    logic        clk_pixel = 1'b0, rst = 1'b1, new_frame = 1'b0, active_draw = 1'b0;
    logic [7:0]  msi [3];
    logic [10:0] h_count = 11'd0;
    logic [9:0]  v_count = 10'd0;
    logic        pixel_valid, bar_pixel, peak_pixel;
    logic [7:0]  bar_index;
    logic [7:0]  bar_level [3];
    int checks = 0, passes = 0;
    int ks [6] = '{1, 2, 10, 49, 50, 60};
    int ke [6] = '{196, 192, 160, 4, 0, 0};

    always #5 clk_pixel = ~clk_pixel;

    instrument_meter dut (
        .clk_pixel(clk_pixel), .rst(rst), .new_frame(new_frame),
        .max_sample_intensity(msi), .h_count(h_count), .v_count(v_count),
        .active_draw(active_draw), .pixel_valid(pixel_valid), .bar_pixel(bar_pixel),
        .peak_pixel(peak_pixel), .bar_index(bar_index), .bar_level(bar_level)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic pix(input int h, input int v, input logic a);
        h_count = 11'(h);
        v_count = 10'(v);
        active_draw = a;
        tick;
        tick;
    endtask

    task automatic frame(input int a, input int b, input int c);
        msi = '{8'(a), 8'(b), 8'(c)};
        new_frame = 1'b1;
        tick;
        new_frame = 1'b0;
        msi = '{8'd7, 8'd7, 8'd7};
    endtask

    initial begin
        msi = '{8'd0, 8'd0, 8'd0};
        h_count = 11'd144;
        v_count = 10'd700;
        active_draw = 1'b1;
        tick; tick; tick;
        check("rst_valid", pixel_valid, 0);
        check("rst_bar", bar_pixel, 0);
        check("rst_peak", peak_pixel, 0);
        check("rst_index", bar_index, 0);
        check("rst_level0", bar_level[0], 0);
        rst = 1'b0;
        active_draw = 1'b0;
        frame(200, 0, 255);
        check("load0", bar_level[0], 200);
        check("load1", bar_level[1], 0);
        check("load2", bar_level[2], 255);
        tick; tick;
        check("ignore_in", bar_level[0], 200);
        msi = '{8'd0, 8'd0, 8'd0};
        new_frame = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick;
            for (int j = 0; j < 6; j++)
                if (k == ks[j]) check($sformatf("decay_f%0d", k), bar_level[0], ke[j]);
        end
        new_frame = 1'b0;
        check("decay_bar2", bar_level[2], 15);
        check("decay_bar1", bar_level[1], 0);
        frame(0, 10, 0);
        check("set_bar1", bar_level[1], 10);
        check("set_bar2", bar_level[2], 11);
        pix(144, 700, 1);
        check("base_valid", pixel_valid, 1);
        check("base_bar", bar_pixel, 1);
        check("base_index", bar_index, 1);
        pix(144, 690, 1);
        check("ht10_bar", bar_pixel, 0);
        check("ht10_index", bar_index, 1);
        pix(144, 691, 1);
        check("ht9_bar", bar_pixel, 1);
        pix(144, 701, 1);
        check("below_bar", bar_pixel, 0);
        pix(180, 700, 1);
        check("gap_bar", bar_pixel, 0);
        check("gap_index", bar_index, 0);
        pix(112, 700, 1);
        check("left_edge", bar_pixel, 1);
        pix(175, 700, 1);
        check("right_edge", bar_pixel, 1);
        pix(176, 700, 1);
        check("past_edge", bar_pixel, 0);
        pix(208, 700, 1);
        check("bar2_index", bar_index, 2);
        check("bar2_bar", bar_pixel, 1);
        pix(144, 700, 0);
        check("blank_valid", pixel_valid, 0);
        check("blank_bar", bar_pixel, 0);
        check("blank_peak", peak_pixel, 0);
        check("blank_index", bar_index, 0);
        h_count = 11'd144; v_count = 10'd700; active_draw = 1'b1;
        tick;
        h_count = 11'd180;
        tick;
        check("stream_a", bar_pixel, 1);
        h_count = 11'd144; v_count = 10'd690;
        tick;
        check("stream_b_index", bar_index, 0);
        tick;
        check("stream_c_bar", bar_pixel, 0);
        check("stream_c_index", bar_index, 1);
        h_count = 11'd144; v_count = 10'd691;
        tick;
        msi = '{8'd0, 8'd0, 8'd0};
        new_frame = 1'b1;
        tick;
        new_frame = 1'b0;
        check("inflight_bar", bar_pixel, 1);
        check("inflight_level", bar_level[1], 6);
        pix(144, 695, 1);
        check("lit_before_rst", bar_pixel, 1);
        rst = 1'b1;
        tick;
        check("midrst_valid", pixel_valid, 0);
        check("midrst_bar", bar_pixel, 0);
        check("midrst_index", bar_index, 0);
        check("midrst_level", bar_level[1], 0);
        rst = 1'b0;
        tick; tick;
        check("post_rst_bar", bar_pixel, 0);
        check("post_rst_valid", pixel_valid, 1);
        check("post_rst_level", bar_level[1], 0);
        frame(180, 0, 0);
        pix(64, 520, 1);
`ifdef METER_PEAK_MARKER_EN
        check("peak_set", peak_pixel, 1);
        check("peak_not_bar", bar_pixel, 0);
        for (int k = 0; k < 15; k++) frame(0, 0, 0);
        pix(64, 520, 1);
        check("peak_hold", peak_pixel, 1);
        frame(0, 0, 0);
        check("peak_level", bar_level[0], 116);
        pix(64, 520, 1);
        check("peak_left_180", peak_pixel, 0);
        pix(64, 521, 1);
        check("peak_fall_179", peak_pixel, 1);
`else
        check("peak_off", peak_pixel, 0);
        pix(64, 700, 1);
        check("peak_off_base", peak_pixel, 0);
        check("peak_off_bar", bar_pixel, 1);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
